ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the registered operands, funct3 and destination address of an M-extension instruction. It computes the result over multiple cycles and holds the pipeline through a stall request. The result is presented with a one-cycle done pulse for the EX/MEM register to capture.

Parameters:
XLEN, 32, operand/result width (only 32 is supported)
CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
clk  input  1  rising-edge clock
r_n  input  1  asynchronous active-low reset
start  input  1  M-op valid from ID/EX (ALUCode_ex decodes to M-extension)
flush  input  1  kill the in-flight op (branch/exception flush)
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1Data  input  32  operand A (already forwarded)
rs2Data  input  32  operand B (already forwarded)
rdAddr  input  5  destination register of the op
busy  output  1  unit not IDLE
stall_req  output  1  freeze PC, IF/ID and ID/EX (en=0)
done  output  1  one-cycle pulse; result valid
result  output  32  computed value, held until next accept
rdAddr_out  output  5  destination latched at accept

Behaviour:
- Clock and reset: one clock, clk; reset r_n is asynchronous, active-low. On reset, state=IDLE, busy=0, stall_req=0, done=0, result=0, rdAddr_out=0, counter=0.
- States:
  - IDLE: on start=1 and flush=0, latch funct3 and rdAddr; compute operand magnitudes and the sign of the result according to funct3. Go to CALC, or go to SPEC for special division cases.
  - CALC: one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide); counter runs 0..31. After the step with counter=31, go to FIX.
  - FIX: apply sign correction, select low/high product word or quotient/remainder, register result. Go to DONE.
  - SPEC: register the special result. Go to DONE.
  - DONE: done=1 for exactly this cycle. Go to IDLE.
- Stall: stall_req = (IDLE & start & ~flush) | CALC | FIX | SPEC. stall_req=0 in DONE, so ID/EX advances on the same edge that EX/MEM captures the result. busy=1 in every state except IDLE.
- Latency: start is sampled at edge N. Normal ops: CALC covers edges N+1..N+32, FIX at N+33, done high during the cycle after edge N+33 (34 cycles of stall). Special cases: done high during the cycle after edge N+1.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - DIV, REM: signed.
  - Remainder takes the sign of the dividend; quotient is negated when the operand signs differ.
- Special cases, resolved via SPEC with no iteration:
  - Divisor=0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - DIV with rs1=0x80000000 and rs2=0xFFFFFFFF: result 0x80000000. REM with the same operands: result 0.
  - Multiply has no special path.
- Simultaneous and mid-operation events:
  - start while busy is ignored; it is not queued.
  - flush in any state: the next state is IDLE and done stays 0. result and rdAddr_out keep their previous values. flush has priority over start in IDLE.
  - r_n asserted mid-operation aborts immediately to reset values.
- Arithmetic: the product uses a 64-bit accumulator; the divide uses a 33-bit partial remainder. No overflow is flagged. Wrap-around follows the RV32M definition.

Test Plan:
- Reset: drive r_n=0 mid-CALC -> all outputs 0 and state IDLE asynchronously; after release, busy=0.
- MUL/MULHU: rs1=0xFFFFFFFF, rs2=0x00000002 -> MUL result 0xFFFFFFFE, MULHU result 0x00000001. done occurs 34 cycles after the start edge, with stall_req high for those 34 cycles and low in DONE.
- MULH/MULHSU: rs1=0xFFFFFFFF (-1), rs2=0xFFFFFFFF -> MULH result 0x00000000, MULHSU result 0xFFFFFFFF.
- DIV/REM signed: rs1=-7 (0xFFFFFFF9), rs2=2 -> DIV result 0xFFFFFFFD (-3), REM result 0xFFFFFFFF (-1). rdAddr_out equals the latched rdAddr, e.g. 5'd12.
- Special cases: DIVU x/0 with rs1=0x1234 -> 0xFFFFFFFF and REMU -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. done high 2 cycles after start.
- Flush and ignored start: flush at counter=10 -> IDLE next edge, done never pulses, result keeps its prior value. A second start asserted while busy -> no effect on the in-flight result.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit for the EX stage
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            r_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1Data,
  input  logic [XLEN-1:0] rs2Data,
  input  logic [4:0]      rdAddr,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rdAddr_out
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_FIX  = 3'd2,
    S_SPEC = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  state_t state, state_nxt;

  // Latched operation context; opa/opb hold operand magnitudes.
  logic [2:0]        op;
  logic [4:0]        rd_lat;
  logic              neg_res;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   opa;
  logic [XLEN-1:0]   opb;
  // Multiply: full product accumulator. Divide: low word is the dividend
  // being shifted out while quotient bits are shifted in.
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   rem;

  // Decode of the incoming op.
  logic            is_div, rs1_signed, rs2_signed, a_neg, b_neg, neg_in;
  logic            div_zero, div_ovf, spec_hit;
  logic [XLEN-1:0] a_mag, b_mag, spec_val;

  // Iteration and final-correction datapath.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

  // Operand signedness, magnitudes, result sign and special-case detection.
  always_comb begin
    is_div     = funct3[2];
    rs1_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
    rs2_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg      = rs1_signed & rs1Data[XLEN-1];
    b_neg      = rs2_signed & rs2Data[XLEN-1];
    a_mag      = a_neg ? -rs1Data : rs1Data;
    b_mag      = b_neg ? -rs2Data : rs2Data;
    // Remainder follows the dividend; product and quotient follow the XOR.
    neg_in     = (is_div & funct3[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero   = is_div & (rs2Data == '0);
    div_ovf    = is_div & ~funct3[0] & (rs1Data == INT_MIN) & (rs2Data == '1);
    spec_hit   = div_zero | div_ovf;
    if (div_zero) begin
      spec_val = funct3[1] ? rs1Data : '1;
    end else begin
      spec_val = funct3[1] ? '0 : INT_MIN;
    end
  end

  // One radix-2 step for each algorithm plus sign fix-up of the final value.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opa};
    mul_step  = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
    div_shift = {rem, acc[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb};
    // A non-negative difference is always below the divisor, so bit XLEN is 0.
    div_ge    = (div_diff[XLEN+1:XLEN] == 2'b00);
    prod_fix  = neg_res ? -acc : acc;
    quo_fix   = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix   = neg_res ? -rem : rem;
    if (op[2]) begin
      fix_val = op[1] ? rem_fix : quo_fix;
    end else begin
      fix_val = (op == 3'b000) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nxt = spec_hit ? S_SPEC : S_CALC;
        S_CALC:  if (cnt == LAST_STEP) state_nxt = S_FIX;
        S_FIX:   state_nxt = S_DONE;
        S_SPEC:  state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Status outputs; stall drops in DONE so ID/EX advances as EX/MEM captures.
  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    stall_req = ((state == S_IDLE) & start & ~flush) |
                (state == S_CALC) | (state == S_FIX) | (state == S_SPEC);
  end

  // Datapath registers: accept, iterate, and commit result/destination.
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      op         <= '0;
      rd_lat     <= '0;
      neg_res    <= 1'b0;
      cnt        <= '0;
      opa        <= '0;
      opb        <= '0;
      acc        <= '0;
      rem        <= '0;
      result     <= '0;
      rdAddr_out <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op      <= funct3;
            rd_lat  <= rdAddr;
            neg_res <= neg_in;
            cnt     <= '0;
            opa     <= a_mag;
            opb     <= b_mag;
            rem     <= '0;
            if (spec_hit) begin
              acc <= {{XLEN{1'b0}}, spec_val};
            end else begin
              acc <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
            end
          end
        end
        S_CALC: begin
          cnt <= (cnt == LAST_STEP) ? '0 : cnt + CNT_W'(1);
          if (op[2]) begin
            rem             <= div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            acc[XLEN-1:0]   <= {acc[XLEN-2:0], div_ge};
          end else begin
            acc <= mul_step;
          end
        end
        S_FIX: begin
          result     <= fix_val;
          rdAddr_out <= rd_lat;
        end
        S_SPEC: begin
          result     <= acc[XLEN-1:0];
          rdAddr_out <= rd_lat;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

  logic        clk;
  logic        r_n;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic [4:0]  rdAddr;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rdAddr_out;

  int checks   = 0;
  int failures = 0;

  ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk        (clk),
    .r_n        (r_n),
    .start      (start),
    .flush      (flush),
    .funct3     (funct3),
    .rs1Data    (rs1Data),
    .rs2Data    (rs2Data),
    .rdAddr     (rdAddr),
    .busy       (busy),
    .stall_req  (stall_req),
    .done       (done),
    .result     (result),
    .rdAddr_out (rdAddr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op and check result, destination, done latency and stall length.
  // A nonzero poke cycle asserts a stray start mid-operation with junk operands.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat, input int poke);
    int n;
    int stalls;
    @(negedge clk);
    funct3 = f3; rs1Data = a; rs2Data = b; rdAddr = rd; start = 1'b1;
    #1;
    stalls = stall_req ? 1 : 0;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 60) begin
      if (stall_req) stalls++;
      if (n == poke) begin
        start = 1'b1; funct3 = 3'b000; rs1Data = 32'hDEAD_BEEF;
        rs2Data = 32'h0000_0003; rdAddr = 5'd31;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!done) begin
      check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check_eq({tag, "_result"}, result, exp);
      check_eq({tag, "_rd"}, 32'(rdAddr_out), 32'(rd));
      check_eq({tag, "_latency"}, 32'(n), 32'(exp_lat));
      check_eq({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
      check_eq({tag, "_stall_in_done"}, 32'(stall_req), 32'd0);
      @(negedge clk);
      check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
      check_eq({tag, "_idle_after"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int dones;
    int n;
    r_n = 1'b0; start = 1'b0; flush = 1'b0;
    funct3 = 3'b000; rs1Data = '0; rs2Data = '0; rdAddr = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_stall", 32'(stall_req), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_rd", 32'(rdAddr_out), 32'd0);
    r_n = 1'b1;

    run_op("mul",      3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 5'd1,  32'hFFFF_FFFE, 34, 0);
    run_op("mulhu",    3'b011, 32'hFFFF_FFFF, 32'h0000_0002, 5'd2,  32'h0000_0001, 34, 0);
    run_op("mulh",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'h0000_0000, 34, 0);
    run_op("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 34, 0);
    run_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd5,  32'h4000_0000, 34, 0);
    run_op("mul_lo",   3'b000, 32'h1234_5678, 32'h0000_0010, 5'd6,  32'h2345_6780, 34, 0);
    run_op("div_neg",  3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd12, 32'hFFFF_FFFD, 34, 0);
    run_op("rem_neg",  3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd12, 32'hFFFF_FFFF, 34, 0);
    run_op("div_nd",   3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 5'd8,  32'hFFFF_FFFD, 34, 0);
    run_op("rem_nd",   3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 5'd9,  32'h0000_0001, 34, 0);
    run_op("divu",     3'b101, 32'h0000_0064, 32'h0000_0007, 5'd10, 32'h0000_000E, 34, 0);
    run_op("remu",     3'b111, 32'h0000_0064, 32'h0000_0007, 5'd11, 32'h0000_0002, 34, 0);
    run_op("divu_z",   3'b101, 32'h0000_1234, 32'h0000_0000, 5'd13, 32'hFFFF_FFFF, 2, 0);
    run_op("remu_z",   3'b111, 32'h0000_1234, 32'h0000_0000, 5'd14, 32'h0000_1234, 2, 0);
    run_op("div_z",    3'b100, 32'h8765_4321, 32'h0000_0000, 5'd15, 32'hFFFF_FFFF, 2, 0);
    run_op("rem_z",    3'b110, 32'h8765_4321, 32'h0000_0000, 5'd16, 32'h8765_4321, 2, 0);
    run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 2, 0);
    run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h0000_0000, 2, 0);
    run_op("divu_ign", 3'b101, 32'h0000_0064, 32'h0000_0007, 5'd19, 32'h0000_000E, 34, 5);

    // Flush at counter=10: unit returns to IDLE, no done, outputs retained.
    @(negedge clk);
    funct3 = 3'b000; rs1Data = 32'd3; rs2Data = 32'd5; rdAddr = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (n = 1; n < 10; n++) begin
      if (done) dones++;
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check_eq("flush_no_done", 32'(dones), 32'd0);
    check_eq("flush_result_kept", result, 32'h0000_000E);
    check_eq("flush_rd_kept", 32'(rdAddr_out), 32'd19);

    run_op("after_flush", 3'b000, 32'd3, 32'd5, 5'd7, 32'd15, 34, 0);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    funct3 = 3'b011; rs1Data = 32'h1234_5678; rs2Data = 32'h9ABC_DEF0; rdAddr = 5'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    r_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_stall", 32'(stall_req), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    check_eq("arst_result", result, 32'd0);
    check_eq("arst_rd", 32'(rdAddr_out), 32'd0);
    @(negedge clk);
    r_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
